// File: rtl/lamp_conflict_monitor.sv
// Independent lamp-pattern checker for the intersection controller: decodes both
// lamp sides, tracks per-side dwell and latches the first fault, requesting flashing red.
module lamp_conflict_monitor #(
  parameter int unsigned MIN_GREEN  = 16,
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_red,
  input  logic       ns_yellow,
  input  logic       ns_green,
  input  logic       ew_red,
  input  logic       ew_yellow,
  input  logic       ew_green,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red
);

  localparam logic [7:0] MIN_GREEN_C  = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_YELLOW_C = 8'(MIN_YELLOW);
  localparam logic [7:0] FLASH_LAST_C = 8'(FLASH_HALF - 1);
  localparam logic [7:0] DWELL_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_MONITOR,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    LAMP_R,
    LAMP_Y,
    LAMP_G
  } lamp_t;

  typedef enum logic [2:0] {
    CODE_NONE        = 3'd0,
    CODE_INVALID     = 3'd1,
    CODE_CONFLICT    = 3'd2,
    CODE_TRANSITION  = 3'd3,
    CODE_SHORT_YELLOW = 3'd4,
    CODE_SHORT_GREEN = 3'd5
  } code_t;

  function automatic logic lamp_valid(input logic [2:0] rgb);
    return (rgb == 3'b100) || (rgb == 3'b010) || (rgb == 3'b001);
  endfunction

  function automatic lamp_t lamp_decode(input logic [2:0] rgb);
    case (rgb)
      3'b010:  return LAMP_Y;
      3'b001:  return LAMP_G;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic step_legal(input lamp_t prev, input lamp_t cur);
    return (prev == cur)
        || (prev == LAMP_R && cur == LAMP_G)
        || (prev == LAMP_G && cur == LAMP_Y)
        || (prev == LAMP_Y && cur == LAMP_R);
  endfunction

  function automatic logic [7:0] dwell_next(input lamp_t prev, input lamp_t cur,
                                            input logic [7:0] dwell);
    if (prev != cur)
      return 8'd1;
    else if (dwell == DWELL_MAX)
      return dwell;
    else
      return dwell + 8'd1;
  endfunction

  state_t     state;
  lamp_t      ns_prev, ew_prev;
  logic [7:0] ns_dwell, ew_dwell;
  logic [7:0] flash_cnt;

  logic [2:0] ns_rgb, ew_rgb;
  logic       ns_ok, ew_ok;
  lamp_t      ns_cur, ew_cur;
  code_t      static_code, monitor_code;

  assign ns_rgb = {ns_red, ns_yellow, ns_green};
  assign ew_rgb = {ew_red, ew_yellow, ew_green};
  assign ns_ok  = lamp_valid(ns_rgb);
  assign ew_ok  = lamp_valid(ew_rgb);
  assign ns_cur = lamp_decode(ns_rgb);
  assign ew_cur = lamp_decode(ew_rgb);

  always_comb begin
    static_code = CODE_NONE;
    if (!ns_ok || !ew_ok)
      static_code = CODE_INVALID;
    else if (ns_cur != LAMP_R && ew_cur != LAMP_R)
      static_code = CODE_CONFLICT;
  end

  // Dynamic checks compare the new sample against the held history, each side independently.
  always_comb begin
    monitor_code = static_code;
    if (static_code == CODE_NONE) begin
      if (!step_legal(ns_prev, ns_cur) || !step_legal(ew_prev, ew_cur))
        monitor_code = CODE_TRANSITION;
      else if ((ns_prev == LAMP_Y && ns_cur == LAMP_R && ns_dwell < MIN_YELLOW_C) ||
               (ew_prev == LAMP_Y && ew_cur == LAMP_R && ew_dwell < MIN_YELLOW_C))
        monitor_code = CODE_SHORT_YELLOW;
      else if ((ns_prev == LAMP_G && ns_cur == LAMP_Y && ns_dwell < MIN_GREEN_C) ||
               (ew_prev == LAMP_G && ew_cur == LAMP_Y && ew_dwell < MIN_GREEN_C))
        monitor_code = CODE_SHORT_GREEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STARTUP;
      fault      <= 1'b0;
      fault_code <= '0;
      flash_red  <= 1'b0;
      flash_cnt  <= '0;
      ns_prev    <= LAMP_R;
      ew_prev    <= LAMP_R;
      ns_dwell   <= DWELL_MAX;
      ew_dwell   <= DWELL_MAX;
    end else begin
      case (state)
        ST_STARTUP: begin
          if (static_code != CODE_NONE) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= static_code;
            flash_red  <= 1'b1;
            flash_cnt  <= '0;
          end else begin
            // Captured states start fully dwelled so the first transition cannot look short.
            state    <= ST_MONITOR;
            ns_prev  <= ns_cur;
            ew_prev  <= ew_cur;
            ns_dwell <= DWELL_MAX;
            ew_dwell <= DWELL_MAX;
          end
        end
        ST_MONITOR: begin
          if (monitor_code != CODE_NONE) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= monitor_code;
            flash_red  <= 1'b1;
            flash_cnt  <= '0;
          end else begin
            ns_prev  <= ns_cur;
            ew_prev  <= ew_cur;
            ns_dwell <= dwell_next(ns_prev, ns_cur, ns_dwell);
            ew_dwell <= dwell_next(ew_prev, ew_cur, ew_dwell);
          end
        end
        ST_FAULT: begin
          if (clear) begin
            state      <= ST_STARTUP;
            fault      <= 1'b0;
            fault_code <= '0;
            flash_red  <= 1'b0;
            flash_cnt  <= '0;
          end else if (flash_cnt == FLASH_LAST_C) begin
            flash_red <= ~flash_red;
            flash_cnt <= '0;
          end else begin
            flash_cnt <= flash_cnt + 8'd1;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: doc/lamp_conflict_monitor.md
# lamp_conflict_monitor

Independent checker that watches the six lamp drives produced by the intersection controller and latches a fault when the lamps show a dangerous or illegal pattern. It sits beside the controller, samples the lamp lines each clock, tracks per-direction lamp state and dwell time, and on any violation raises `fault`, records a fault code, and drives a flashing-red override request until software clears it.

## Interface
Parameters:
- MIN_GREEN, 16: minimum cycles a direction must show green before going yellow (1..255)
- MIN_YELLOW, 3: minimum cycles a direction must show yellow before going red (1..255)
- FLASH_HALF, 8: half-period of `flash_red` in cycles (1..255)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- ns_red, ns_yellow, ns_green  in  1 each  NS lamp drives, synchronous to clk
- ew_red, ew_yellow, ew_green  in  1 each  EW lamp drives, synchronous to clk
- clear  in  1  fault acknowledge; effective only in FAULT
- fault  out  1  latched fault indication
- fault_code  out  3  first fault seen: 0 none, 1 invalid lamp pattern, 2 conflict, 3 illegal transition, 4 short yellow, 5 short green
- flash_red  out  1  override request; toggles while in FAULT

## Operation
- Per-side decode of {red,yellow,green}: 100=R, 010=Y, 001=G; any other value is INVALID.
- Per-side registers: previous lamp state (R/Y/G) and 8-bit dwell counter. On a sample equal to the previous state, dwell = min(dwell+1, 255). On a change, dwell = 1.
- States: STARTUP, MONITOR, FAULT.
- STARTUP, entered from reset and from clear: evaluates the static checks (1, 2) only. If both pass, it captures the lamp states, sets both dwell counters to 255 (treated as satisfied), and moves to MONITOR.
- MONITOR evaluates every sample against these checks, highest priority first:
  - 1: either side INVALID.
  - 2: both sides non-red (G or Y) at the same time.
  - 3: a per-side transition other than hold, R->G, G->Y or Y->R.
  - 4: Y->R with previous yellow dwell < MIN_YELLOW.
  - 5: G->Y with previous green dwell < MIN_GREEN.
- On any hit: go to FAULT, latch the code of the highest-priority hit, freeze the history registers.
- FAULT ignores all further violations; `fault_code` holds the first code. `flash_red` toggles every FLASH_HALF cycles, starting at 1 in the first FAULT cycle.
- `clear` high in FAULT: go to STARTUP, and `fault`, `fault_code` and `flash_red` drop to 0. `clear` has priority over anything sampled in the same cycle. `clear` is ignored in STARTUP and MONITOR.

## Timing
- Reset values (asynchronous, immediate): state=STARTUP, fault=0, fault_code=0, flash_red=0, dwell=255, previous states=R.
- Lamps are sampled on each rising clk. `fault`, `fault_code` and `flash_red` are registered and assert on the edge that samples the violation, so they are visible one cycle after the violating lamp value is presented.
- A static violation present at STARTUP faults on the first sampling edge after reset release.
- Clear-to-refault: if the violation persists after clear, `fault` reasserts 2 cycles after `clear` is sampled (STARTUP cycle, then re-fault).
- Dwell boundaries: a yellow held exactly MIN_YELLOW cycles then red is legal; MIN_YELLOW-1 cycles faults with code 4. Green follows the same rule against MIN_GREEN.
- Dwell saturates at 255 and never wraps.
- Both sides changing on the same sample are each checked independently. The conflict check uses the new sample.
- `rst` asserted mid-FAULT clears everything immediately, with no clear handshake.

## Test plan
- Legal sequence: NS G 40 cycles, Y 3, R; then EW G 20, Y 3, R; loop 3 times -> `fault` stays 0 and `fault_code` stays 0 throughout.
- Conflict: from NS=G/EW=R, drive EW=001 -> next cycle `fault`=1, `fault_code`=2, `flash_red`=1 for 8 cycles, then 0 for 8, repeating.
- Skip yellow: NS G for 20 cycles then NS=100 -> `fault_code`=3. Separately, drive R->Y -> `fault_code`=3.
- Short dwell: NS Y for 2 cycles then R -> code 4. NS Y for 3 cycles then R -> no fault. NS G for 15 cycles then Y -> code 5.
- Priority: drive NS=011 while EW=001 (both INVALID and conflict) -> `fault_code`=1. A later legal-looking conflict while in FAULT leaves the code at 1.
- Clear and reset: in FAULT, pulse `clear` with lamps legal -> next cycle all outputs 0, and monitoring resumes with no false code 4/5 on the first transition. Pulse `clear` with the conflict still present -> `fault`=1 again 2 cycles later. Assert `rst` mid-flash -> outputs 0 immediately.
